// File: rtl/pipe_trace_buffer_pkg.sv
// Shared encodings for the pipeline trace buffer and the stage info-bus field layout
// (also used by the per-stage debug tap).
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRE     = 2'd1,
    ST_POST    = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_t;

  // MODE_RSVD captures like MODE_ALL.
  typedef enum logic [1:0] {
    MODE_ALL    = 2'd0,
    MODE_VALID  = 2'd1,
    MODE_CHANGE = 2'd2,
    MODE_RSVD   = 2'd3
  } trace_mode_t;

  localparam int INFO_VALID_BIT = 0;
  localparam int INFO_PC_LSB    = 32;
  localparam int INFO_PC_W      = 32;

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Read-back port of the trace buffer: index request in, {stamp, info} record out.
interface pipe_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 208
);
  // rd_en with rd_idx is a one-cycle request (no back-pressure); the next cycle rd_valid=1
  // qualifies rd_data when honoured, otherwise rd_valid=0 and rd_data keeps its old value.
  logic [$clog2(DEPTH)-1:0] rd_idx;
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;

  modport master (output rd_idx, output rd_en, input rd_data, input rd_valid);
  modport slave  (input rd_idx, input rd_en, output rd_data, output rd_valid);
endinterface

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port whose output holds when not reading.
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 208
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Records timestamped snapshots of one pipeline stage into a circular buffer, stops a
// programmable number of records after a PC trigger, then serves indexed read-back.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int INFO_W    = 192,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int PC_LSB    = INFO_PC_LSB,
  parameter int VALID_BIT = INFO_VALID_BIT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STAGES*INFO_W-1:0]     info_in,
  input  logic [$clog2(STAGES)-1:0]    stage_sel,
  input  logic [1:0]                   mode,
  input  logic [31:0]                  trig_pc,
  input  logic [$clog2(DEPTH):0]       post_cnt,
  input  logic                         arm,
  pipe_trace_buffer_if.slave           rd,
  output logic [1:0]                   state_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STAGES);
  localparam int DW = TS_W + INFO_W;

  trace_state_t      state_q, state_d;
  trace_mode_t       mode_q, mode_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [31:0]       trig_q, trig_d;
  logic [CW-1:0]     post_q, post_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic              have_last_q, have_last_d;
  logic              rd_valid_q, rd_valid_d;

  logic [INFO_W-1:0] word;
  logic              w_valid;
  logic [31:0]       w_pc;
  logic              qual, capture, hit, rd_hit;
  logic [CW-1:0]     addr_full;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     ram_rdata;

  always_comb begin
    word = info_in[0 +: INFO_W];
    for (int s = 1; s < STAGES; s++) begin
      if (sel_q == SW'(s)) word = info_in[s*INFO_W +: INFO_W];
    end
  end

  assign w_valid = word[VALID_BIT];
  assign w_pc    = word[PC_LSB +: 32];

  always_comb begin
    case (mode_q)
      MODE_VALID:  qual = w_valid;
      MODE_CHANGE: qual = w_valid && (!have_last_q || (w_pc != last_pc_q));
      default:     qual = 1'b1;
    endcase
  end

  // Arm has priority over capture and trigger detection in its own cycle.
  assign capture = ((state_q == ST_PRE) || (state_q == ST_POST)) && qual && !arm;
  assign hit     = w_valid && (w_pc == trig_q);

  // Index 0 is the oldest record held; power-of-two depth makes the wrap a truncation.
  assign addr_full = {1'b0, wr_ptr_q} - count_q + {1'b0, rd.rd_idx};
  assign rd_addr   = addr_full[AW-1:0];
  assign rd_hit    = rd.rd_en && (state_q == ST_STOPPED) && ({1'b0, rd.rd_idx} < count_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    trig_d      = trig_q;
    post_d      = post_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    ts_d        = ts_q + TS_W'(1);
    rd_valid_d  = rd_hit;
    if (arm) begin
      state_d     = ST_PRE;
      mode_d      = trace_mode_t'(mode);
      sel_d       = (int'(stage_sel) < STAGES) ? stage_sel : '0;
      trig_d      = trig_pc;
      post_d      = (post_cnt > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_cnt;
      wr_ptr_d    = '0;
      count_d     = '0;
      have_last_d = 1'b0;
    end else if (capture) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      last_pc_d   = w_pc;
      have_last_d = 1'b1;
      if (state_q == ST_PRE && hit) begin
        state_d = (post_q == '0) ? ST_STOPPED : ST_POST;
      end else if (state_q == ST_POST) begin
        post_d = post_q - CW'(1);
        if (post_q == CW'(1)) state_d = ST_STOPPED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ALL;
      sel_q       <= '0;
      trig_q      <= '0;
      post_q      <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      trig_q      <= trig_d;
      post_q      <= post_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .DATA_W(DW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (capture),
    .waddr (wr_ptr_q),
    .wdata ({ts_q, word}),
    .re    (rd_hit),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd.rd_data  = ram_rdata;
  assign rd.rd_valid = rd_valid_q;
  assign state_o     = state_q;
  assign count_o     = count_q;

endmodule
